ahb_gpio_param: RTL and testbench

- Parametrised AHB-Lite GPIO slave, the successor to the fixed 16-bit GPIO.
- Adds per-bit direction, a set/clear/toggle output path, per-bit edge-detect interrupts with sticky write-1-to-clear status, and a generalised parity bit on both ports.
- Sits on the AHB-Lite decoder/mux alongside the other peripherals.
- Single clock; HSEL is the only address decode.

---
 rtl/ahb_gpio_param.sv | 182 ++++++++++++++++++
 tb/tb_ahb_gpio_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_gpio_param.sv
// ahb_gpio_param: parametrised AHB-Lite GPIO slave.
// Features: per-bit direction, SET/CLR/TGL output updates, per-bit edge
// interrupts with sticky W1C status, and parity on the pad ports.
// Optional macro AHB_GPIO_INPUT_SYNC_EN adds a 2-flop input synchronizer
// ahead of the sampled input register.
module ahb_gpio_param #(
  parameter int              WIDTH         = 16,
  parameter logic [WIDTH-1:0] DIR_RESET    = '0,
  parameter bit              IRQ_BOTH_EDGE = 1'b0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH:0]   GPIOIN,
  output logic [WIDTH:0]   GPIOOUT,
  input  logic             PARITYSEL,
  output logic             PARITYERR,
  output logic             IRQ
);

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_DIR    = 3'd1;
  localparam logic [2:0] OFF_SET    = 3'd2;
  localparam logic [2:0] OFF_CLR    = 3'd3;
  localparam logic [2:0] OFF_TGL    = 3'd4;
  localparam logic [2:0] OFF_IRQEN  = 3'd5;
  localparam logic [2:0] OFF_STATUS = 3'd6;

  // Address-phase capture
  logic             r_ap_valid;
  logic             r_ap_write;
  logic [2:0]       r_ap_off;

  // Architectural registers
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irqen;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH:0]   r_in_s;
  logic [WIDTH-1:0] r_in_p;
  logic             r_parityerr;
  logic [31:0]      r_hrdata;

  // Next-state and helper wires
  logic             w_addr_valid;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_out_next;
  logic [WIDTH-1:0] w_dir_next;
  logic [WIDTH-1:0] w_irqen_next;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_status_next;
  logic [WIDTH:0]   w_in_s_next;
  logic [WIDTH-1:0] w_in_p_next;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_data_view;
  logic [WIDTH-1:0] w_rd_word;
  logic [WIDTH-1:0] w_gpio_data;
  logic             w_unused;

  assign w_addr_valid = HSEL & HTRANS[1] & HREADY;
  assign w_wr         = r_ap_valid & r_ap_write;
  assign w_wdata      = HWDATA[WIDTH-1:0];

  // Address bits outside [4:2], HTRANS[0] and HWDATA above the GPIO width carry no meaning here
  assign w_unused = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:WIDTH]};

`ifdef AHB_GPIO_INPUT_SYNC_EN
  logic [WIDTH:0] r_sync;

  // First synchronizer stage; r_in_s acts as the second stage
  always_ff @(posedge HCLK) begin
    if (HRESET) r_sync <= '0;
    else        r_sync <= GPIOIN;
  end

  assign w_in_s_next = r_sync;
`else
  assign w_in_s_next = GPIOIN;
`endif

  // Apply the data-phase write to the software-visible registers
  always_comb begin
    w_out_next   = r_out;
    w_dir_next   = r_dir;
    w_irqen_next = r_irqen;
    w_w1c        = '0;
    if (w_wr) begin
      case (r_ap_off)
        OFF_DATA:   w_out_next   = w_wdata;
        OFF_DIR:    w_dir_next   = w_wdata;
        OFF_SET:    w_out_next   = r_out | w_wdata;
        OFF_CLR:    w_out_next   = r_out & ~w_wdata;
        OFF_TGL:    w_out_next   = r_out ^ w_wdata;
        OFF_IRQEN:  w_irqen_next = w_wdata;
        OFF_STATUS: w_w1c        = w_wdata;
        default:    ;
      endcase
    end
  end

  // Per-bit edge detect, previous-sample tracking and read view
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic w_rise;
      logic w_fall;
      assign w_rise = r_in_s[gi] & ~r_in_p[gi];
      assign w_fall = ~r_in_s[gi] & r_in_p[gi];
      // Only input-configured bits can raise status
      assign w_edge[gi] = ~r_dir[gi] & (w_rise | (IRQ_BOTH_EDGE & w_fall));
      // A bit switching from output to input restarts edge history from its new sample
      assign w_in_p_next[gi] = (r_dir[gi] & ~w_dir_next[gi]) ? w_in_s_next[gi] : r_in_s[gi];
      assign w_data_view[gi] = w_dir_next[gi] ? w_out_next[gi] : w_in_s_next[gi];
    end
  endgenerate

  // Edge set takes priority over a same-cycle write-1-to-clear
  assign w_status_next = (r_status & ~w_w1c) | w_edge;

  // Read mux evaluated on post-update state so a write followed by a read sees the new value
  always_comb begin
    w_rd_word = '0;
    case (HADDR[4:2])
      OFF_DATA:   w_rd_word = w_data_view;
      OFF_DIR:    w_rd_word = w_dir_next;
      OFF_IRQEN:  w_rd_word = w_irqen_next;
      OFF_STATUS: w_rd_word = w_status_next;
      default:    w_rd_word = '0;
    endcase
  end

  // Capture the address phase; reset drops any pending data-phase write
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_ap_valid <= 1'b0;
      r_ap_write <= 1'b0;
      r_ap_off   <= '0;
    end else begin
      r_ap_valid <= w_addr_valid;
      r_ap_write <= HWRITE;
      r_ap_off   <= HADDR[4:2];
    end
  end

  // Register state update, input sampling, parity check and read data
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_out       <= '0;
      r_dir       <= DIR_RESET;
      r_irqen     <= '0;
      r_status    <= '0;
      r_in_s      <= '0;
      r_in_p      <= '0;
      r_parityerr <= 1'b0;
      r_hrdata    <= '0;
    end else begin
      r_out       <= w_out_next;
      r_dir       <= w_dir_next;
      r_irqen     <= w_irqen_next;
      r_status    <= w_status_next;
      r_in_s      <= w_in_s_next;
      r_in_p      <= w_in_p_next;
      r_parityerr <= (^r_in_s) ^ PARITYSEL;
      r_hrdata    <= (w_addr_valid & ~HWRITE) ? 32'(w_rd_word) : 32'd0;
    end
  end

  assign w_gpio_data = r_out & r_dir;
  assign GPIOOUT     = {(^w_gpio_data) ^ PARITYSEL, w_gpio_data};
  assign PARITYERR   = r_parityerr;
  assign IRQ         = |(r_status & r_irqen);
  assign HREADYOUT   = 1'b1;
  assign HRDATA      = r_hrdata;

endmodule

// File: tb/tb_ahb_gpio_param.sv
// Testbench for ahb_gpio_param (WIDTH=16, rising-edge interrupts).
// Directed checks from the test plan followed by randomized bus/pin traffic,
// all compared against a cycle-level behavioural model of the register map.
module tb_ahb_gpio_param;

  localparam int W    = 16;
  localparam bit BOTH = 1'b0;
`ifdef AHB_GPIO_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET, HSEL, HWRITE, HREADY, PARITYSEL;
  logic          HREADYOUT, PARITYERR, IRQ;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [1:0]    HTRANS;
  logic [W:0]    GPIOIN, GPIOOUT;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahb_gpio_param #(
    .WIDTH(W),
    .DIR_RESET(16'h0000),
    .IRQ_BOTH_EDGE(BOTH)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .GPIOIN(GPIOIN),
    .GPIOOUT(GPIOOUT), .PARITYSEL(PARITYSEL), .PARITYERR(PARITYERR),
    .IRQ(IRQ)
  );

  // Reference model state
  logic [W-1:0] m_out, m_dir, m_ien, m_st, m_in_p;
  logic [W:0]   m_in_s;
  logic         m_perr;
  logic [31:0]  m_rd;
  bit           p_v, p_w;
  logic [2:0]   p_off;
  logic [W:0]   pin_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the currently driven inputs, then
  // clock the DUT and compare every output.
  task automatic step();
    logic [W-1:0] wd, o, d, ie, clr, edg, st_n, inp_n;
    logic [W:0]   ins_n;
    logic [W-1:0] e;
    logic [31:0]  rd;
    bit           av;
    if (HRESET) begin
      m_out = '0; m_dir = '0; m_ien = '0; m_st = '0;
      m_in_s = '0; m_in_p = '0; m_perr = 1'b0; m_rd = '0;
      p_v = 1'b0; p_w = 1'b0; p_off = '0;
      pin_q.delete();
      for (int i = 0; i < LAT - 1; i++) pin_q.push_back('0);
    end else begin
      wd = HWDATA[W-1:0];
      o = m_out; d = m_dir; ie = m_ien; clr = '0;
      if (p_v && p_w) begin
        case (p_off)
          3'd0: o = wd;
          3'd1: d = wd;
          3'd2: o = o | wd;
          3'd3: o = o & ~wd;
          3'd4: o = o ^ wd;
          3'd5: ie = wd;
          3'd6: clr = wd;
          default: ;
        endcase
      end
      pin_q.push_back(GPIOIN);
      ins_n = pin_q.pop_front();
      edg = '0;
      for (int i = 0; i < W; i++) begin
        if (!m_dir[i] && (m_in_s[i] != m_in_p[i]) && (BOTH || m_in_s[i])) edg[i] = 1'b1;
        inp_n[i] = (m_dir[i] && !d[i]) ? ins_n[i] : m_in_s[i];
      end
      st_n = (m_st & ~clr) | edg;
      av = HSEL && HTRANS[1] && HREADY;
      rd = '0;
      if (av && !HWRITE) begin
        case (HADDR[4:2])
          3'd0: for (int i = 0; i < W; i++) rd[i] = d[i] ? o[i] : ins_n[i];
          3'd1: rd = 32'(d);
          3'd5: rd = 32'(ie);
          3'd6: rd = 32'(st_n);
          default: rd = '0;
        endcase
      end
      m_perr = (^m_in_s) ^ PARITYSEL;
      m_out = o; m_dir = d; m_ien = ie; m_st = st_n;
      m_in_s = ins_n; m_in_p = inp_n; m_rd = rd;
      p_v = av; p_w = HWRITE; p_off = HADDR[4:2];
    end
    @(posedge HCLK);
    #1;
    e = m_out & m_dir;
    chk("hrdata", 64'(HRDATA), 64'(m_rd));
    chk("gpioout", 64'(GPIOOUT), 64'({(^e) ^ PARITYSEL, e}));
    chk("irq", 64'(IRQ), 64'(|(m_st & m_ien)));
    chk("parityerr", 64'(PARITYERR), 64'(m_perr));
    chk("hreadyout", 64'(HREADYOUT), 64'd1);
  endtask

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = $urandom;
    step();
  endtask

  task automatic bus_wr(input logic [2:0] off, input logic [15:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'(off) << 2; HWDATA = $urandom;
    step();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
    HWDATA = ($urandom & 32'hFFFF0000) | 32'(data);
    step();
    $display("WR off=%0h data=%04h", off, data);
  endtask

  task automatic bus_rd(input logic [2:0] off, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'(off) << 2; HWDATA = $urandom;
    step();
    d = HRDATA;
    $display("RD off=%0h data=%08h", off, d);
  endtask

  // Write immediately followed by a read of the same register
  task automatic wr_rd(input logic [2:0] off, input logic [15:0] data, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'(off) << 2; HWDATA = $urandom;
    step();
    HWRITE = 1'b0; HWDATA = ($urandom & 32'hFFFF0000) | 32'(data);
    step();
    d = HRDATA;
    $display("WR/RD off=%0h wdata=%04h rdata=%08h", off, data, d);
  endtask

  initial begin
    logic [31:0] d;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
    HADDR = '0; HWDATA = '0; GPIOIN = '0; PARITYSEL = 1'b1;

    // Reset
    step();
    step();
    chk("rst_gpioout", 64'(GPIOOUT), 64'h10000);
    chk("rst_hrdata", 64'(HRDATA), 64'h0);
    chk("rst_irq", 64'(IRQ), 64'h0);
    chk("rst_perr", 64'(PARITYERR), 64'h0);
    HRESET = 1'b0; PARITYSEL = 1'b0;
    repeat (3) idle();

    // All outputs, DATA write and readback
    bus_wr(3'd1, 16'hFFFF);
    bus_wr(3'd0, 16'h1234);
    chk("out_1234", 64'(GPIOOUT), 64'h11234);
    bus_rd(3'd0, d);
    chk("rd_1234", 64'(d), 64'h1234);
    idle();

    // Mixed direction
    bus_wr(3'd1, 16'h00FF);
    bus_wr(3'd0, 16'hFFFF);
    chk("out_00ff", 64'(GPIOOUT), 64'h000FF);
    GPIOIN = 17'h0A500;
    repeat (LAT + 1) idle();
    bus_rd(3'd0, d);
    chk("rd_a5ff", 64'(d), 64'hA5FF);
    idle();

    // SET / CLR / TGL
    bus_wr(3'd1, 16'hFFFF);
    bus_wr(3'd0, 16'h0000);
    bus_wr(3'd2, 16'h0F00);
    bus_wr(3'd3, 16'h0300);
    bus_wr(3'd4, 16'h00F0);
    chk("out_0cf0", 64'(GPIOOUT), 64'h00CF0);
    wr_rd(3'd5, 16'h0001, d);
    chk("b2b_irqen", 64'(d), 64'h1);
    idle();

    // Rising-edge interrupt
    bus_wr(3'd1, 16'h0000);
    GPIOIN = '0;
    repeat (LAT + 2) idle();
    bus_wr(3'd6, 16'hFFFF);
    bus_rd(3'd6, d);
    chk("st_clear0", 64'(d), 64'h0);
    GPIOIN = 17'h00001;
    repeat (LAT) idle();
    chk("irq_pre", 64'(IRQ), 64'h0);
    idle();
    chk("irq_rise", 64'(IRQ), 64'h1);
    bus_rd(3'd6, d);
    chk("st_rise", 64'(d), 64'h1);

    // W1C landing in the same cycle as a new rising edge
    GPIOIN = '0;
    repeat (LAT + 2) idle();
    GPIOIN = 17'h00001;
    for (int i = 0; i < LAT - 1; i++) idle();
    bus_wr(3'd6, 16'h0001);
    chk("w1c_vs_edge_irq", 64'(IRQ), 64'h1);
    bus_rd(3'd6, d);
    chk("st_set_wins", 64'(d), 64'h1);
    repeat (2) idle();
    bus_wr(3'd6, 16'h0001);
    bus_rd(3'd6, d);
    chk("st_w1c", 64'(d), 64'h0);
    chk("irq_w1c", 64'(IRQ), 64'h0);

    // Input parity error
    GPIOIN = 17'h10000; PARITYSEL = 1'b0;
    repeat (LAT + 1) idle();
    chk("perr_set", 64'(PARITYERR), 64'h1);
    GPIOIN = 17'h00000;
    repeat (LAT + 1) idle();
    chk("perr_clr", 64'(PARITYERR), 64'h0);

    // Randomized traffic including mid-transfer resets
    for (int n = 0; n < 600; n++) begin
      HRESET = ($urandom_range(0, 99) == 0);
      HSEL   = $urandom_range(0, 3) != 0;
      HTRANS = 2'($urandom);
      HWRITE = $urandom_range(0, 1) == 1;
      HADDR  = $urandom;
      HWDATA = $urandom;
      HREADY = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 3) == 0) GPIOIN = 17'($urandom);
      if ($urandom_range(0, 15) == 0) PARITYSEL = ~PARITYSEL;
      step();
    end
    HRESET = 1'b0; HREADY = 1'b1;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
